// File: rtl/pmu_ahbm_pkg.sv
// Shared encodings for the PMU AHB-lite command master: FSM states and the fixed
// AHB control values it drives.
package pmu_ahbm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Anything other than OKAY is treated as an error response.
    function automatic logic hresp_is_err(input logic [1:0] hresp);
        return hresp != HRESP_OKAY;
    endfunction

endpackage

// File: rtl/pmu_ahb_cmd_master.sv
// Purpose: valid/ready command to single non-pipelined AHB-lite word transfer (PMU_AHBM_TIMEOUT_EN adds a wait timeout).
// Latency: accept at cycle 0, ADDR 1, DATA 2, response valid 3; each hready_i=0 cycle adds one.
// Backpressure: one command outstanding; req_ready_o low until the response is consumed via rsp_ready_i.
module pmu_ahb_cmd_master
    import pmu_ahbm_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TO_CNT_WIDTH   = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,

    output logic                  hsel_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic                  hwrite_o,
    output logic [1:0]            htrans_o,
    output logic [2:0]            hsize_o,
    output logic [2:0]            hburst_o,
    output logic [3:0]            hprot_o,
    output logic                  hmastlock_o,
    output logic [DATA_WIDTH-1:0] hwdata_o,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i,
    input  logic [DATA_WIDTH-1:0] hrdata_i
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_req_ready;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err_sticky;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_accept;
    logic                  w_misaligned;
    logic                  w_hresp_err;
    logic                  w_data_err;
    logic                  w_timeout;

    assign w_accept     = (r_state == ST_IDLE) & r_req_ready & req_valid_i;
    assign w_misaligned = req_addr_i[1:0] != 2'b00;
    assign w_hresp_err  = hresp_is_err(hresp_i);
    assign w_data_err   = r_err_sticky | w_hresp_err;

`ifdef PMU_AHBM_TIMEOUT_EN
    logic [TO_CNT_WIDTH-1:0] r_to_cnt;
    logic [TO_CNT_WIDTH-1:0] w_to_cnt_inc;
    logic                    w_waiting;

    assign w_waiting    = ((r_state == ST_ADDR) | (r_state == ST_DATA)) & ~hready_i;
    assign w_to_cnt_inc = r_to_cnt + TO_CNT_WIDTH'(1);
    assign w_timeout    = w_waiting & (w_to_cnt_inc == TO_CNT_WIDTH'(TIMEOUT_CYCLES));

    // Count restarts on every state change so ADDR and DATA waits are budgeted separately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_to_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_to_cnt <= '0;
        end else if (w_waiting) begin
            r_to_cnt <= w_to_cnt_inc;
        end
    end
`else
    logic w_unused_to;
    assign w_unused_to = ^{TIMEOUT_CYCLES, TO_CNT_WIDTH};
    assign w_timeout   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_misaligned ? ST_RESP : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_timeout) begin
                    w_state_nxt = ST_RESP;
                end else if (hready_i) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_timeout || hready_i) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_err_sticky  <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Ready is registered so it stays low on the cycle a response is consumed.
            r_req_ready <= (w_state_nxt == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write      <= req_write_i;
                        r_addr       <= req_addr_i;
                        r_wdata      <= req_wdata_i;
                        r_err_sticky <= 1'b0;
                        if (w_misaligned) begin
                            r_rsp_err <= 1'b1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_timeout) begin
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_timeout) begin
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                    end else begin
                        if (w_hresp_err) begin
                            r_err_sticky <= 1'b1;
                        end
                        if (hready_i) begin
                            r_rsp_err   <= w_data_err;
                            r_rsp_rdata <= (!r_write && !w_data_err) ? hrdata_i : '0;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o   = r_req_ready;
    assign rsp_valid_o   = (r_state == ST_RESP);
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

    assign hsel_o        = (r_state == ST_ADDR);
    assign htrans_o      = hsel_o ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr_o       = r_addr;
    assign hwrite_o      = hsel_o & r_write;
    assign hwdata_o      = ((r_state == ST_DATA) && r_write) ? r_wdata : '0;
    assign hsize_o       = HSIZE_WORD;
    assign hburst_o      = HBURST_SINGLE;
    assign hprot_o       = HPROT_DEFAULT;
    assign hmastlock_o   = 1'b0;

endmodule

// File: tb/tb_pmu_ahb_cmd_master.sv
// Bench for pmu_ahb_cmd_master: per-cycle transaction model plus literal latency/status pins.
module tb_pmu_ahb_cmd_master;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic        req_ready_o;
    logic        rsp_valid_o, rsp_err_o, rsp_timeout_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        hsel_o, hwrite_o, hmastlock_o;
    logic [31:0] haddr_o, hwdata_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o, hburst_o;
    logic [3:0]  hprot_o;
    logic        hready_i = 1'b1;
    logic [1:0]  hresp_i = 2'b00;
    logic [31:0] hrdata_i = '0;

    pmu_ahb_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .hsel_o(hsel_o), .haddr_o(haddr_o), .hwrite_o(hwrite_o), .htrans_o(htrans_o),
        .hsize_o(hsize_o), .hburst_o(hburst_o), .hprot_o(hprot_o), .hmastlock_o(hmastlock_o),
        .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
    );

    initial forever #5 clk_i = ~clk_i;

    // One entry per clock: inputs to apply and the outputs the master must show.
    typedef struct packed {
        logic        req_valid;
        logic        req_write;
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic        rsp_ready;
        logic        hready;
        logic [1:0]  hresp;
        logic [31:0] hrdata;
        logic        e_req_ready;
        logic        e_rsp_valid;
        logic        e_rsp_err;
        logic        e_rsp_to;
        logic [31:0] e_rdata;
        logic        e_hsel;
        logic [1:0]  e_htrans;
        logic [31:0] e_haddr;
        logic        e_hwrite;
        logic        chk_bus;
        logic [31:0] e_hwdata;
        logic        chk_wdata;
    } cyc_t;

    cyc_t        q[$];
    cyc_t        cur;
    bit          cur_vld = 1'b0;
    bit          hold = 1'b0;
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, acc_cyc = 0, last_lat = -1, n_rsp = 0, n_err_rsp = 0, n0 = 0, e0 = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0, last_to = 1'b0, prev_rv = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c             = '0;
        c.hready      = 1'b1;
        c.hrdata      = 32'hDEAD_BEEF;
        c.e_req_ready = 1'b1;
        return c;
    endfunction

    // Expands one command into its cycle sequence from the transfer rules:
    // accept, (aw+1) address cycles, (dw+1) data cycles, then response until consumed.
    task automatic plan_txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input int aw, input int dw, input bit two_err,
                            input logic [31:0] rd, input int rdly, input bit early);
        cyc_t c;
        bit   err;
        bit   to;
        int   ndata;
        c           = idle_cyc();
        c.req_valid = 1'b1;
        c.req_write = wr;
        c.req_addr  = a;
        c.req_wdata = d;
        if (early && q.size() > 0) begin
            q[q.size()-1].req_valid = 1'b1;
            q[q.size()-1].req_write = wr;
            q[q.size()-1].req_addr  = a;
            q[q.size()-1].req_wdata = d;
        end
        q.push_back(c);
        err = (a[1:0] != 2'b00);
        to  = 1'b0;
        if (!err) begin
            for (int i = 0; i <= aw; i++) begin
                c             = idle_cyc();
                c.e_req_ready = 1'b0;
                c.hready      = (i == aw);
                c.e_hsel      = 1'b1;
                c.e_htrans    = 2'b10;
                c.e_haddr     = a;
                c.e_hwrite    = wr;
                c.chk_bus     = 1'b1;
                q.push_back(c);
            end
            ndata = dw + 1;
`ifdef PMU_AHBM_TIMEOUT_EN
            if (dw >= TO) begin
                ndata = TO;
                to    = 1'b1;
            end
`endif
            for (int i = 0; i < ndata; i++) begin
                c             = idle_cyc();
                c.e_req_ready = 1'b0;
                c.hready      = !to && (i == dw);
                if (two_err && i >= dw - 1) begin
                    c.hresp = 2'b01;
                    err     = 1'b1;
                end
                if (i == dw) c.hrdata = rd;
                c.e_hwdata  = d;
                c.chk_wdata = wr;
                q.push_back(c);
            end
            if (to) err = 1'b1;
        end
        for (int i = 0; i <= rdly; i++) begin
            c             = idle_cyc();
            c.e_req_ready = 1'b0;
            c.e_rsp_valid = 1'b1;
            c.e_rsp_err   = err;
            c.e_rsp_to    = to;
            c.e_rdata     = (wr || err) ? 32'h0 : rd;
            c.rsp_ready   = (i == rdly);
            q.push_back(c);
        end
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_req_ready"}, 32'(req_ready_o), 32'h0);
        chk({p, "_rsp_valid"}, 32'(rsp_valid_o), 32'h0);
        chk({p, "_rsp_rdata"}, rsp_rdata_o, 32'h0);
        chk({p, "_rsp_err"},   32'(rsp_err_o), 32'h0);
        chk({p, "_rsp_to"},    32'(rsp_timeout_o), 32'h0);
        chk({p, "_hsel"},      32'(hsel_o), 32'h0);
        chk({p, "_htrans"},    32'(htrans_o), 32'h0);
        chk({p, "_haddr"},     haddr_o, 32'h0);
        chk({p, "_hwrite"},    32'(hwrite_o), 32'h0);
        chk({p, "_hwdata"},    hwdata_o, 32'h0);
    endtask

    task automatic drain();
        do begin
            @(posedge clk_i);
            #2;
        end while (q.size() != 0);
        @(posedge clk_i);
        #2;
    endtask

    // Driver: applies one planned entry per clock, shortly after the edge.
    initial forever begin
        @(posedge clk_i);
        #1;
        if (!hold && q.size() > 0) begin
            cur     = q.pop_front();
            cur_vld = 1'b1;
        end else begin
            cur     = idle_cyc();
            cur_vld = 1'b0;
        end
        req_valid_i = cur.req_valid;
        req_write_i = cur.req_write;
        req_addr_i  = cur.req_addr;
        req_wdata_i = cur.req_wdata;
        rsp_ready_i = cur.rsp_ready;
        hready_i    = cur.hready;
        hresp_i     = cur.hresp;
        hrdata_i    = cur.hrdata;
    end

    // Compare process: checks every planned cycle and records handshake timing.
    initial forever begin
        @(negedge clk_i);
        cyc++;
        if (!rst_i) begin
            if (req_valid_i && req_ready_o) acc_cyc = cyc;
            if (rsp_valid_o && !prev_rv) begin
                last_lat   = cyc - acc_cyc;
                last_rdata = rsp_rdata_o;
                last_err   = rsp_err_o;
                last_to    = rsp_timeout_o;
            end
            if (rsp_valid_o && rsp_ready_i) begin
                n_rsp++;
                if (rsp_err_o) n_err_rsp++;
            end
        end
        prev_rv = rsp_valid_o;
        if (cur_vld) begin
            chk("req_ready", 32'(req_ready_o), 32'(cur.e_req_ready));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(cur.e_rsp_valid));
            chk("rsp_err",   32'(rsp_err_o), 32'(cur.e_rsp_err));
            chk("rsp_to",    32'(rsp_timeout_o), 32'(cur.e_rsp_to));
            chk("rsp_rdata", rsp_rdata_o, cur.e_rdata);
            chk("hsel",      32'(hsel_o), 32'(cur.e_hsel));
            chk("htrans",    32'(htrans_o), 32'(cur.e_htrans));
            chk("hsize",     32'(hsize_o), 32'h2);
            chk("hburst",    32'(hburst_o), 32'h0);
            chk("hprot",     32'(hprot_o), 32'h3);
            chk("hmastlock", 32'(hmastlock_o), 32'h0);
            if (cur.chk_bus) begin
                chk("haddr",  haddr_o, cur.e_haddr);
                chk("hwrite", 32'(hwrite_o), 32'(cur.e_hwrite));
            end
            if (cur.chk_wdata) chk("hwdata", hwdata_o, cur.e_hwdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_reset_vals("rst");
        repeat (3) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);

        // Zero-wait write.
        plan_txn(1'b1, 32'h8010_0000, 32'h0000_0002, 0, 0, 1'b0, 32'h0, 0, 1'b0);
        drain();
        chk("wr_latency", 32'(last_lat), 32'd3);
        chk("wr_err", 32'(last_err), 32'h0);

        // Read with three data-phase wait states.
        plan_txn(1'b0, 32'h8010_00AC, 32'h0, 0, 3, 1'b0, 32'hCAFE_CAFE, 1, 1'b0);
        drain();
        chk("rd_latency", 32'(last_lat), 32'd6);
        chk("rd_rdata", last_rdata, 32'hCAFE_CAFE);

        // Two-cycle ERROR on a write, then a read offered while the response is consumed.
        n0 = n_rsp;
        e0 = n_err_rsp;
        plan_txn(1'b1, 32'h8010_00B0, 32'h0BAD_0BAD, 0, 1, 1'b1, 32'h0, 2, 1'b0);
        plan_txn(1'b0, 32'h8010_0004, 32'h0, 1, 0, 1'b0, 32'h1234_5678, 0, 1'b1);
        drain();
        chk("err_rsp_count", 32'(n_rsp - n0), 32'd2);
        chk("err_err_count", 32'(n_err_rsp - e0), 32'd1);
        chk("ovl_latency", 32'(last_lat), 32'd4);
        chk("ovl_rdata", last_rdata, 32'h1234_5678);

        // Misaligned address: no bus activity, response next cycle.
        plan_txn(1'b0, 32'h8010_00B2, 32'h0, 0, 0, 1'b0, 32'h0, 0, 1'b0);
        drain();
        chk("mis_latency", 32'(last_lat), 32'd1);
        chk("mis_err", 32'(last_err), 32'h1);
        chk("mis_rdata", last_rdata, 32'h0);

        // Slave stalls the data phase for 100 cycles.
        plan_txn(1'b0, 32'h8010_0010, 32'h0, 0, 100, 1'b0, 32'h0000_55AA, 0, 1'b0);
        drain();
`ifdef PMU_AHBM_TIMEOUT_EN
        chk("stall_latency", 32'(last_lat), 32'd10);
        chk("stall_err", 32'(last_err), 32'h1);
        chk("stall_to", 32'(last_to), 32'h1);
        chk("stall_rdata", last_rdata, 32'h0);
`else
        chk("stall_latency", 32'(last_lat), 32'd103);
        chk("stall_err", 32'(last_err), 32'h0);
        chk("stall_to", 32'(last_to), 32'h0);
        chk("stall_rdata", last_rdata, 32'h0000_55AA);
`endif

        // Reset during the data phase of a read: accept, address, two data cycles.
        plan_txn(1'b0, 32'h8010_0030, 32'h0, 0, 10, 1'b0, 32'h1111_1111, 0, 1'b0);
        while (q.size() > 4) void'(q.pop_back());
        do begin
            @(posedge clk_i);
            #2;
        end while (q.size() != 0);
        hold    = 1'b1;
        cur_vld = 1'b0;
        n0      = n_rsp;
        rst_i   = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        hold = 1'b0;
        plan_txn(1'b1, 32'h8010_0020, 32'hA5A5_A5A5, 0, 0, 1'b0, 32'h0, 0, 1'b0);
        drain();
        chk("post_rst_latency", 32'(last_lat), 32'd3);
        chk("post_rst_rsp_count", 32'(n_rsp - n0), 32'd1);
        chk("post_rst_err", 32'(last_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
